// File: rtl/aes_round_engine.sv
// aes_round_engine: AES-128 cipher datapath and round controller driven by key_expansion
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = T[{~a, 3'b000} +: 8];
endmodule

module aes_round_engine #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] plaintext,
    output logic         key_start,
    input  logic         key_done,
    input  logic [127:0] round_key,
    output logic [3:0]   round_number,
    output logic [127:0] cyphertext,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, KEYWAIT, ROUND, DONE} state_t;
    state_t state, state_n;
    logic [127:0] st, srw, mcw;
    logic [7:0] sb [16];
    logic [3:0] rnd;
    logic accept, last;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign accept = load && (state == IDLE || state == DONE);
    assign last = rnd == 4'(NUM_ROUNDS);
    assign round_number = (state == ROUND) ? rnd : 4'd0;
    assign done = state == DONE;

    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sb[i]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign srw[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
        end
        assign a0 = srw[127-32*c -: 8];
        assign a1 = srw[119-32*c -: 8];
        assign a2 = srw[111-32*c -: 8];
        assign a3 = srw[103-32*c -: 8];
        assign mcw[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                      xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end

    // State register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // Next-state: load only counts in IDLE/DONE, key_done only in KEYWAIT
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = load ? KEYWAIT : IDLE;
            KEYWAIT: state_n = key_done ? ROUND : KEYWAIT;
            ROUND:   state_n = last ? DONE : ROUND;
            DONE:    state_n = load ? KEYWAIT : DONE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: one full round per ROUND cycle, final round lands in cyphertext
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            key_start  <= 1'b0;
            rnd        <= 4'd0;
            st         <= '0;
            cyphertext <= '0;
        end else begin
            key_start <= accept;
            if (accept) st <= plaintext;
            if (state == KEYWAIT && key_done) rnd <= 4'd0;
            if (state == ROUND) begin
                rnd <= last ? rnd : rnd + 4'd1;
                if (rnd == 4'd0) st <= st ^ round_key;
                else if (!last) st <= mcw ^ round_key;
                else cyphertext <= srw ^ round_key;
            end
        end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed FIPS-197 vectors, timing and ignore/reset checks with a behavioural key schedule
module tb_aes_round_engine;
    logic         clk = 1'b0;
    logic         reset, load, key_done, key_start, done;
    logic [127:0] plaintext, round_key, cyphertext;
    logic [3:0]   round_number;
    logic [127:0] rk [0:10];
    int n_cmp = 0, n_err = 0;

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    assign round_key = (round_number <= 4'd10) ? rk[round_number] : 128'h0;

    aes_round_engine #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .reset(reset), .load(load), .plaintext(plaintext),
        .key_start(key_start), .key_done(key_done), .round_key(round_key),
        .round_number(round_number), .cyphertext(cyphertext), .done(done)
    );

    function automatic logic [7:0] xtm(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xtm(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h00;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0]), sbox_m(t[31:24])} ^ {rc, 24'h0};
                rc = xtm(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [127:0] key, input logic [127:0] pt,
                       input logic [127:0] ct, input logic [127:0] prev, input bit noise);
        expand(key);
        chk({tag, " ct_before"}, cyphertext, prev);
        plaintext = pt;
        load = 1'b1;
        tick;
        load = 1'b0;
        chk({tag, " key_start_pulse"}, 128'(key_start), 128'd1);
        chk({tag, " done_drop"}, 128'(done), 128'd0);
        chk({tag, " ct_held"}, cyphertext, prev);
        if (noise) begin
            load = 1'b1;
            plaintext = ~pt;
        end
        tick;
        load = 1'b0;
        chk({tag, " key_start_end"}, 128'(key_start), 128'd0);
        chk({tag, " rn_keywait"}, 128'(round_number), 128'd0);
        tick;
        chk({tag, " no_restart"}, 128'(key_start), 128'd0);
        key_done = 1'b1;
        tick;
        key_done = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            chk($sformatf("%s rn%0d", tag, r), 128'(round_number), 128'(r));
            chk($sformatf("%s done_low%0d", tag, r), 128'(done), 128'd0);
            chk($sformatf("%s ks_low%0d", tag, r), 128'(key_start), 128'd0);
            load = noise && r == 4;
            tick;
            load = 1'b0;
        end
        chk({tag, " done_rise"}, 128'(done), 128'd1);
        chk({tag, " cyphertext"}, cyphertext, ct);
        chk({tag, " rn_done"}, 128'(round_number), 128'd0);
        tick;
        chk({tag, " done_hold"}, 128'(done), 128'd1);
        chk({tag, " ct_stable"}, cyphertext, ct);
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        key_done = 1'b0;
        plaintext = '0;
        for (int i = 0; i <= 10; i++) rk[i] = '0;
        tick;
        tick;
        chk("rst key_start", 128'(key_start), 128'd0);
        chk("rst round_number", 128'(round_number), 128'd0);
        chk("rst cyphertext", cyphertext, 128'd0);
        chk("rst done", 128'(done), 128'd0);
        reset = 1'b0;
        tick;
        key_done = 1'b1;
        tick;
        key_done = 1'b0;
        chk("idle key_done rn", 128'(round_number), 128'd0);
        chk("idle key_done ks", 128'(key_start), 128'd0);
        tick;
        chk("idle key_done done", 128'(done), 128'd0);
        run("appB", KEY1, PT1, CT1, 128'd0, 1'b1);
        run("b2b", KEY2, PT2, CT2, CT1, 1'b0);
        expand(KEY1);
        plaintext = PT1;
        load = 1'b1;
        tick;
        load = 1'b0;
        tick;
        key_done = 1'b1;
        tick;
        key_done = 1'b0;
        repeat (5) tick;
        chk("pre_reset rn", 128'(round_number), 128'd5);
        reset = 1'b1;
        #1;
        chk("async done", 128'(done), 128'd0);
        chk("async ct", cyphertext, 128'd0);
        chk("async rn", 128'(round_number), 128'd0);
        tick;
        reset = 1'b0;
        key_done = 1'b1;
        tick;
        key_done = 1'b0;
        chk("post_reset rn", 128'(round_number), 128'd0);
        chk("post_reset ks", 128'(key_start), 128'd0);
        repeat (12) tick;
        chk("post_reset done", 128'(done), 128'd0);
        chk("post_reset ct", cyphertext, 128'd0);
        run("appC1", KEY2, PT2, CT2, 128'd0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
